// File: rtl/irq_ts_pkg.sv
// rtl/irq_ts_pkg.sv - shared register map, control fields and edge-mode helpers for irq_timestamp_core
package irq_ts_pkg;

  localparam logic [4:0] REG_STATUS = 5'd0;
  localparam logic [4:0] REG_HEAD   = 5'd1;
  localparam logic [4:0] REG_POP    = 5'd2;
  localparam logic [4:0] REG_CTRL   = 5'd3;
  localparam logic [4:0] REG_CNT    = 5'd4;
  localparam logic [4:0] REG_SS     = 5'd5;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_CLR_BIT  = 3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10
  } edge_mode_t;

  typedef struct packed {
    edge_mode_t mode;
    logic       en;
  } ctrl_t;

  // Mode 2'b11 is folded onto rising-edge so the stored mode is always a named value.
  function automatic edge_mode_t decode_mode(input logic [1:0] raw);
    edge_mode_t m;
    case (raw)
      2'b01:   m = EDGE_FALL;
      2'b10:   m = EDGE_BOTH;
      default: m = EDGE_RISE;
    endcase
    return m;
  endfunction

  function automatic logic edge_hit(input edge_mode_t mode, input logic rise, input logic fall);
    logic hit;
    case (mode)
      EDGE_FALL: hit = fall;
      EDGE_BOTH: hit = rise | fall;
      default:   hit = rise;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/ts_fifo.sv
// rtl/ts_fifo.sv - first-word-fall-through synchronous FIFO holding event timestamps
module ts_fifo #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int          DEPTH_N = 1 << AW;
  localparam logic [AW:0] DEPTH   = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem [DEPTH_N];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == DEPTH);
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Clear outranks both ports; a pop frees the slot a same-cycle push needs when full.
  assign do_pop  = pop & ~empty & ~clr;
  assign do_push = push & ~clr & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/irq_timestamp_core.sv
// rtl/irq_timestamp_core.sv - IRQ edge timestamping slot core with tag FIFO and sensor SS pin
// Optional glitch filter on the synchronized IRQ: define IRQ_GLITCH_FILTER_EN.
module irq_timestamp_core #(
  parameter int TS_W        = 32,
  parameter int FIFO_AW     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic        irq,
  output logic        ss
);

  import irq_ts_pkg::*;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_s;
  logic                   level;
  logic                   prev_q;
  logic                   rise;
  logic                   fall;
  logic                   event_hit;

  logic [TS_W-1:0]        cnt_q;
  ctrl_t                  ctrl_q;
  logic                   ovf_q;
  logic                   ss_q;

  logic                   wr_en;
  logic                   pop;
  logic                   ctrl_wr;
  logic                   clr;

  logic [TS_W-1:0]        fifo_dout;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [FIFO_AW:0]       fifo_count;

  logic                   unused_bits;
  assign unused_bits = ^{read, wr_data[31:4]};

  always_ff @(posedge clk) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], irq};
  end
  assign level_s = sync_q[SYNC_STAGES-1];

`ifdef IRQ_GLITCH_FILTER_EN
  localparam int FCW = $clog2(FILTER_LEN) + 1;
  logic [FCW-1:0] stable_cnt;
  logic           filt_q;

  // The filtered level follows only after FILTER_LEN consecutive cycles at the new level.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      filt_q     <= 1'b0;
      stable_cnt <= '0;
    end else if (level_s == filt_q) begin
      stable_cnt <= '0;
    end else if (stable_cnt == FCW'(FILTER_LEN - 1)) begin
      filt_q     <= level_s;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + FCW'(1);
    end
  end
  assign level = filt_q;
`else
  localparam int UNUSED_FILTER_LEN = FILTER_LEN;
  assign level = level_s;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) prev_q <= 1'b0;
    else          prev_q <= level;
  end

  assign rise      = level & ~prev_q;
  assign fall      = ~level & prev_q;
  assign event_hit = ctrl_q.en & edge_hit(ctrl_q.mode, rise, fall);

  assign wr_en   = cs & write;
  assign pop     = wr_en & (addr == REG_POP);
  assign ctrl_wr = wr_en & (addr == REG_CTRL);
  assign clr     = ctrl_wr & wr_data[CTRL_CLR_BIT];

  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_q + TS_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl_q.en   <= 1'b0;
      ctrl_q.mode <= EDGE_RISE;
    end else if (ctrl_wr) begin
      ctrl_q.en   <= wr_data[CTRL_EN_BIT];
      ctrl_q.mode <= decode_mode(wr_data[CTRL_MODE_MSB:CTRL_MODE_LSB]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clr)                    ovf_q <= 1'b0;
    else if (event_hit & fifo_full & ~pop)  ovf_q <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)                           ss_q <= 1'b1;
    else if (wr_en && (addr == REG_SS))     ss_q <= wr_data[0];
  end
  assign ss = ss_q;

  // The tag is the counter value as it reads in the cycle the entry becomes visible.
  ts_fifo #(
    .DW (TS_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (event_hit),
    .pop     (pop),
    .clr     (clr),
    .din     (cnt_q + TS_W'(1)),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    rd_data = '0;
    case (addr)
      REG_STATUS: begin
        rd_data[0]           = fifo_empty;
        rd_data[1]           = ovf_q;
        rd_data[FIFO_AW+2:2] = fifo_count;
      end
      REG_HEAD: rd_data = fifo_empty ? '0 : 32'(fifo_dout);
      REG_CNT:  rd_data = 32'(cnt_q);
      default:  rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_timestamp_core.sv
// tb/tb_irq_timestamp_core.sv - directed self-checking bench for irq_timestamp_core
module tb_irq_timestamp_core;

  localparam int SYNC  = 2;
  localparam int FLEN  = 4;
`ifdef IRQ_GLITCH_FILTER_EN
  localparam int LAT = SYNC + FLEN + 1;
`else
  localparam int LAT = SYNC + 1;
`endif

  localparam logic [4:0] A_STATUS = 5'd0;
  localparam logic [4:0] A_HEAD   = 5'd1;
  localparam logic [4:0] A_POP    = 5'd2;
  localparam logic [4:0] A_CTRL   = 5'd3;
  localparam logic [4:0] A_CNT    = 5'd4;
  localparam logic [4:0] A_SS     = 5'd5;

  logic        clk = 1'b0;
  logic        reset_n, cs, read, write, irq;
  logic [4:0]  addr;
  logic [31:0] wr_data, rd_data;
  logic        ss;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int t;
  int first_stamp;
  int stamps [16];

  irq_timestamp_core #(
    .TS_W(32), .FIFO_AW(4), .SYNC_STAGES(SYNC), .FILTER_LEN(FLEN)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .read(read), .write(write),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .irq(irq), .ss(ss)
  );

  always #5 clk = ~clk;

  // Reference cycle count: zero after a reset edge, +1 on every other edge.
  always @(posedge clk) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  function automatic logic [31:0] st(input int cnt, input logic ovf, input logic emp);
    return (32'(cnt) << 2) | {30'd0, ovf, emp};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rchk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    cs = 1'b1; read = 1'b1; addr = a;
    #1;
    chk(tag, rd_data, exp);
    cs = 1'b0; read = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    tick();
    cs = 1'b0; write = 1'b0; wr_data = '0;
  endtask

  task automatic wait_until(input int target);
    for (int i = 0; i < 2000 && cyc < target; i++) tick();
    chk("wait_bound", 32'(cyc), 32'(target));
  endtask

  task automatic pulse(input int hi, input int lo);
    irq = 1'b1;
    repeat (hi) tick();
    irq = 1'b0;
    repeat (lo) tick();
  endtask

  initial begin
    reset_n = 1'b0; cs = 1'b0; read = 1'b0; write = 1'b0;
    addr = '0; wr_data = '0; irq = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;

    rchk("rst_status", A_STATUS, st(0, 1'b0, 1'b1));
    rchk("rst_head", A_HEAD, 32'd0);
    chk("rst_ss", {31'd0, ss}, 32'd1);
    rchk("rst_cnt", A_CNT, 32'(cyc));

    // Single rising edge at cycle 100
    wr(A_CTRL, 32'h1);
    wait_until(100);
    irq = 1'b1;
    repeat (LAT + 3) tick();
    rchk("t1_status", A_STATUS, st(1, 1'b0, 1'b0));
    rchk("t1_head", A_HEAD, 32'(100 + LAT));
    rchk("t1_cnt", A_CNT, 32'(cyc));
    wr(A_POP, 32'h0);
    rchk("t1_empty", A_STATUS, st(0, 1'b0, 1'b1));

    // Both-edge mode, three toggles 50 apart
    wr(A_CTRL, 32'h5);
    t = cyc;
    irq = 1'b0;
    repeat (50) tick();
    irq = 1'b1;
    repeat (50) tick();
    irq = 1'b0;
    repeat (15) tick();
    rchk("t2_status", A_STATUS, st(3, 1'b0, 1'b0));
    rchk("t2_head0", A_HEAD, 32'(t + LAT));
    wr(A_POP, 32'h0);
    rchk("t2_head1", A_HEAD, 32'(t + 50 + LAT));
    wr(A_POP, 32'h0);
    rchk("t2_head2", A_HEAD, 32'(t + 100 + LAT));
    wr(A_POP, 32'h0);
    rchk("t2_empty", A_STATUS, st(0, 1'b0, 1'b1));
    rchk("t2_head_empty", A_HEAD, 32'd0);

    // 17 rising edges into 16 entries, then clear coincident with a push
    wr(A_CTRL, 32'h1);
    first_stamp = cyc + LAT;
    for (int i = 0; i < 17; i++) pulse(8, 8);
    repeat (5) tick();
    rchk("t3_status_ovf", A_STATUS, st(16, 1'b1, 1'b0));
    rchk("t3_head_first", A_HEAD, 32'(first_stamp));
    irq = 1'b1;
    t = cyc;
    wait_until(t + LAT - 1);
    wr(A_CTRL, 32'h9);
    repeat (5) tick();
    rchk("t3_clear", A_STATUS, st(0, 1'b0, 1'b1));
    rchk("t3_clear_head", A_HEAD, 32'd0);
    irq = 1'b0;
    repeat (15) tick();

    // Full FIFO, push lands on the same cycle as a pop
    for (int i = 0; i < 16; i++) begin
      stamps[i] = cyc + LAT;
      pulse(8, 8);
    end
    repeat (5) tick();
    rchk("t4_full", A_STATUS, st(16, 1'b0, 1'b0));
    irq = 1'b1;
    t = cyc;
    wait_until(t + LAT - 1);
    wr(A_POP, 32'h0);
    repeat (3) tick();
    rchk("t4_status", A_STATUS, st(16, 1'b0, 1'b0));
    rchk("t4_head", A_HEAD, 32'(stamps[1]));
    for (int i = 0; i < 15; i++) wr(A_POP, 32'h0);
    rchk("t4_last_status", A_STATUS, st(1, 1'b0, 1'b0));
    rchk("t4_newest", A_HEAD, 32'(t + LAT));
    wr(A_POP, 32'h0);
    irq = 1'b0;
    repeat (15) tick();

    // Empty FIFO, push and pop in the same cycle
    irq = 1'b1;
    t = cyc;
    wait_until(t + LAT - 1);
    wr(A_POP, 32'h0);
    repeat (3) tick();
    rchk("ep_status", A_STATUS, st(1, 1'b0, 1'b0));
    rchk("ep_head", A_HEAD, 32'(t + LAT));
    wr(A_POP, 32'h0);
    irq = 1'b0;
    repeat (15) tick();

    // Short and long pulses
    t = cyc;
    pulse(2, 15);
`ifdef IRQ_GLITCH_FILTER_EN
    rchk("t5_short", A_STATUS, st(0, 1'b0, 1'b1));
`else
    rchk("t5_short", A_STATUS, st(1, 1'b0, 1'b0));
    rchk("t5_short_head", A_HEAD, 32'(t + LAT));
    wr(A_POP, 32'h0);
`endif
    t = cyc;
    pulse(6, 15);
    rchk("t5_long", A_STATUS, st(1, 1'b0, 1'b0));
    rchk("t5_long_head", A_HEAD, 32'(t + LAT));
    wr(A_POP, 32'h0);

    // Disabled: no pushes
    wr(A_CTRL, 32'h0);
    pulse(8, 15);
    rchk("en_off", A_STATUS, st(0, 1'b0, 1'b1));

    // SS pin and mid-burst reset
    wr(A_SS, 32'h0);
    chk("ss_low", {31'd0, ss}, 32'd0);
    wr(A_CTRL, 32'h1);
    pulse(8, 8);
    pulse(8, 8);
    rchk("pre_rst", A_STATUS, st(2, 1'b0, 1'b0));
    reset_n = 1'b0;
    tick();
    chk("rst_ss_high", {31'd0, ss}, 32'd1);
    rchk("rst_fifo", A_STATUS, st(0, 1'b0, 1'b1));
    rchk("rst_counter", A_CNT, 32'd0);
    reset_n = 1'b1;
    tick();
    rchk("addr7", 5'd7, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
